// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU operation decoder with a HI/LO
// multiply/divide occupancy sequencer. Dependent HI/LO reads and new
// mult/div instructions are stalled while a MULT/DIV is in flight.
module alu_control_seq #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [2:0] ALUOp,
  input  logic [5:0] ALUFunction,
  output logic [3:0] ALUOperation,
  output logic       md_start,
  output logic       md_op,
  output logic       hilo_busy,
  output logic       stall_o
);

  // ALU operation codes
  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_OR      = 4'd1;
  localparam logic [3:0] OP_NOR     = 4'd2;
  localparam logic [3:0] OP_ADD     = 4'd3;
  localparam logic [3:0] OP_SUB     = 4'd4;
  localparam logic [3:0] OP_LUI     = 4'd5;
  localparam logic [3:0] OP_SLL     = 4'd6;
  localparam logic [3:0] OP_SRL     = 4'd7;
  localparam logic [3:0] OP_SLT     = 4'd8;
  localparam logic [3:0] OP_INVALID = 4'd9;
  localparam logic [3:0] OP_MFHI    = 4'd10;
  localparam logic [3:0] OP_MFLO    = 4'd11;
  localparam logic [3:0] OP_MULT    = 4'd12;
  localparam logic [3:0] OP_DIV     = 4'd13;
  localparam logic [3:0] OP_NOP     = 4'd15;

  // Sequencer states
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_BUSY = 2'd1;
  localparam logic [1:0] S_DIV_BUSY = 2'd2;

  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0]           dec_op;
  logic                 is_hilo_op;
  logic                 accept;

  // Decode ALUOp / funct into an ALU operation code
  always_comb begin
    dec_op = OP_INVALID;
    case (ALUOp)
      3'b000: dec_op = OP_ADD;
      3'b001: dec_op = OP_SUB;
      3'b010: dec_op = OP_AND;
      3'b011: dec_op = OP_SLT;
      3'b100: dec_op = OP_ADD;
      3'b101: dec_op = OP_OR;
      3'b110: dec_op = OP_LUI;
      3'b111: begin
        case (ALUFunction)
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100111: dec_op = OP_NOR;
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b101010: dec_op = OP_SLT;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b011000: dec_op = OP_MULT;
          6'b011010: dec_op = OP_DIV;
          6'b010000: dec_op = OP_MFHI;
          6'b010010: dec_op = OP_MFLO;
          default:   dec_op = OP_INVALID;
        endcase
      end
      default: dec_op = OP_INVALID;
    endcase
  end

  // Stall HI/LO consumers and new mult/div while the unit is occupied
  always_comb begin
    hilo_busy  = (state != S_IDLE);
    is_hilo_op = (dec_op == OP_MULT) || (dec_op == OP_DIV) ||
                 (dec_op == OP_MFHI) || (dec_op == OP_MFLO);
    stall_o    = valid_i & hilo_busy & is_hilo_op;
    accept     = valid_i & ~stall_o;
  end

  // Register the decoded op (bubble when not accepted) and run the sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ALUOperation <= OP_NOP;
      md_start     <= 1'b0;
      md_op        <= 1'b0;
    end else begin
      ALUOperation <= accept ? dec_op : OP_NOP;
      md_start     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && dec_op == OP_MULT) begin
            state    <= S_MUL_BUSY;
            cnt      <= MULT_LOAD;
            md_start <= 1'b1;
            md_op    <= 1'b0;
          end else if (accept && dec_op == OP_DIV) begin
            state    <= S_DIV_BUSY;
            cnt      <= DIV_LOAD;
            md_start <= 1'b1;
            md_op    <= 1'b1;
          end
        end
        S_MUL_BUSY, S_DIV_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Testbench for alu_control_seq: scoreboard of expected registered outputs,
// driven from a reference decode table and an independent busy-cycle model.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic [3:0] ALUOperation;
  logic       md_start;
  logic       md_op;
  logic       hilo_busy;
  logic       stall_o;

  int tests = 0;
  int fails = 0;

  // Model state: remaining busy cycles and last started mult/div kind
  int   busy_left = 0;
  logic exp_md_op = 1'b0;

  typedef struct {
    logic [3:0] op;
    logic       start;
    logic       busy;
    logic       mdop;
  } exp_t;
  exp_t sb[$];

  alu_control_seq #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .CNT_WIDTH  (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .ALUOp       (ALUOp),
    .ALUFunction (ALUFunction),
    .ALUOperation(ALUOperation),
    .md_start    (md_start),
    .md_op       (md_op),
    .hilo_busy   (hilo_busy),
    .stall_o     (stall_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_dec(input logic [2:0] a, input logic [5:0] f);
    if (a != 3'b111) begin
      case (a)
        3'd0: return 4'd3;
        3'd1: return 4'd4;
        3'd2: return 4'd0;
        3'd3: return 4'd8;
        3'd4: return 4'd3;
        3'd5: return 4'd1;
        3'd6: return 4'd5;
        default: return 4'd9;
      endcase
    end
    case (f)
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd2;
      6'h20: return 4'd3;
      6'h22: return 4'd4;
      6'h2a: return 4'd8;
      6'h00: return 4'd6;
      6'h02: return 4'd7;
      6'h18: return 4'd12;
      6'h1a: return 4'd13;
      6'h10: return 4'd10;
      6'h12: return 4'd11;
      default: return 4'd9;
    endcase
  endfunction

  // One clock cycle: drive at negedge, check stall, push expectation, check after edge
  task automatic cycle(input logic v, input logic [2:0] a, input logic [5:0] f,
                       output logic accepted);
    logic [3:0] d;
    logic       st;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    valid_i = v; ALUOp = a; ALUFunction = f;
    #1;
    d  = ref_dec(a, f);
    st = v && (busy_left > 0) && (d == 4'd10 || d == 4'd11 || d == 4'd12 || d == 4'd13);
    tests++;
    if (stall_o !== st) begin
      fails++;
      $display("FAIL stall_o: got %b expected %b (ALUOp=%0d funct=%h)", stall_o, st, a, f);
    end
    accepted = v && !st;
    if (busy_left > 0) busy_left--;
    e.start = accepted && (d == 4'd12 || d == 4'd13);
    if (e.start) begin
      busy_left = (d == 4'd12) ? 4 : 32;
      exp_md_op = (d == 4'd13);
    end
    e.op   = accepted ? d : 4'd15;
    e.busy = (busy_left > 0);
    e.mdop = exp_md_op;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    tests++;
    if (ALUOperation !== got.op) begin
      fails++;
      $display("FAIL ALUOperation: got %0d expected %0d (ALUOp=%0d funct=%h)", ALUOperation, got.op, a, f);
    end
    tests++;
    if (md_start !== got.start) begin
      fails++;
      $display("FAIL md_start: got %b expected %b", md_start, got.start);
    end
    tests++;
    if (hilo_busy !== got.busy) begin
      fails++;
      $display("FAIL hilo_busy: got %b expected %b", hilo_busy, got.busy);
    end
    tests++;
    if (md_op !== got.mdop) begin
      fails++;
      $display("FAIL md_op: got %b expected %b", md_op, got.mdop);
    end
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while (busy_left > 0 && n < 100) begin
      cycle(1'b0, 3'b111, 6'h24, acc);
      n++;
    end
    tests++;
    if (busy_left > 0) begin
      fails++;
      $display("FAIL drain_timeout: busy_left %0d expected 0", busy_left);
    end
  endtask

  // Present an instruction and hold it until accepted; returns stall count
  task automatic issue_until_accept(input logic [2:0] a, input logic [5:0] f,
                                    output int stalls);
    logic acc = 1'b0;
    stalls = 0;
    while (!acc && stalls < 100) begin
      cycle(1'b1, a, f, acc);
      if (!acc) stalls++;
    end
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL accept_timeout: stalls %0d without acceptance", stalls);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_i = 1'($urandom); ALUOp = 3'($urandom); ALUFunction = 6'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (ALUOperation !== 4'd15 || hilo_busy !== 1'b0 || md_start !== 1'b0 || md_op !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: op=%0d busy=%b start=%b mdop=%b expected 15/0/0/0",
                 ALUOperation, hilo_busy, md_start, md_op);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    valid_i = 1'b0;
    busy_left = 0;
    exp_md_op = 1'b0;
  endtask

  task automatic test_decode();
    logic acc;
    cycle(1'b1, 3'b111, 6'h20, acc);
    cycle(1'b1, 3'b110, 6'h00, acc);
    cycle(1'b1, 3'b111, 6'h3f, acc);
    for (int unsigned a = 0; a < 7; a++) cycle(1'b1, 3'(a), 6'($urandom), acc);
    for (int unsigned f = 0; f < 64; f++) begin
      cycle(1'b1, 3'b111, 6'(f), acc);
      drain();
    end
  endtask

  task automatic test_mult();
    logic acc;
    cycle(1'b1, 3'b111, 6'h18, acc);
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b000, 6'h00, acc);
  endtask

  task automatic test_mult_mflo();
    logic acc;
    int   stalls;
    cycle(1'b1, 3'b111, 6'h18, acc);
    issue_until_accept(3'b111, 6'h12, stalls);
    tests++;
    if (stalls != 4) begin
      fails++;
      $display("FAIL mflo_stall_count: got %0d expected 4", stalls);
    end
  endtask

  task automatic test_div_overlap();
    logic acc;
    int   stalls;
    cycle(1'b1, 3'b111, 6'h1a, acc);
    cycle(1'b1, 3'b111, 6'h20, acc);
    cycle(1'b1, 3'b111, 6'h00, acc);
    cycle(1'b1, 3'b111, 6'h22, acc);
    issue_until_accept(3'b111, 6'h1a, stalls);
    tests++;
    if (stalls != 29) begin
      fails++;
      $display("FAIL div_stall_count: got %0d expected 29", stalls);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic acc;
    cycle(1'b1, 3'b111, 6'h1a, acc);
    cycle(1'b1, 3'b111, 6'h10, acc);
    @(negedge clk);
    valid_i = 1'b1; ALUOp = 3'b111; ALUFunction = 6'h10;
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (hilo_busy !== 1'b0 || stall_o !== 1'b0 || ALUOperation !== 4'd15 || md_start !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: busy=%b stall=%b op=%0d start=%b expected 0/0/15/0",
               hilo_busy, stall_o, ALUOperation, md_start);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    busy_left = 0;
    exp_md_op = 1'b0;
    cycle(1'b1, 3'b111, 6'h10, acc);
    tests++;
    if (acc !== 1'b1) begin
      fails++;
      $display("FAIL mfhi_after_reset: accepted=%b expected 1", acc);
    end
  endtask

  task automatic test_valid_low();
    logic acc;
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111, 6'h24, acc);
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'b111, 6'h18, acc);
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0;
    ALUOp = 3'b000;
    ALUFunction = 6'h00;
    test_reset();
    test_decode();
    test_mult();
    drain();
    test_mult_mflo();
    drain();
    test_div_overlap();
    test_reset_mid();
    test_valid_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
